// File: rtl/rsa4k_pkg.sv
// Shared types and defaults for the rsa4k word-serial stream front/back end.
package rsa4k_pkg;

  localparam int WIDTH_DEF = 4096;
  localparam int WORD_DEF  = 32;

  localparam logic [1:0] SEC_MSG = 2'd0;
  localparam logic [1:0] SEC_EXP = 2'd1;
  localparam logic [1:0] SEC_MOD = 2'd2;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    HOLD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/rsa4k_wshift.sv
// WIDTH-bit word shifter: shift right by WORD with a new word entering at the MSB,
// or parallel load. Parallel load wins over shift.
module rsa4k_wshift #(
  parameter int WIDTH = 4096,
  parameter int WORD  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             load,
  input  logic [WORD-1:0]  din,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)       q_d = pin;
    else if (shift) q_d = {din, q_q[WIDTH-1:WORD]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/rsa4k_stream_if.sv
// Word-serial operand loader / cypher drainer around the rsa4k core.
// Optional message < modulus range check: define RSA4K_SIF_RANGE_CHECK_EN.
module rsa4k_stream_if
  import rsa4k_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int WORD  = WORD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WORD-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WORD-1:0]  m_data,
  output logic             m_last,
  output logic             busy,
  output logic             err,
  output logic             core_go,
  output logic [WIDTH-1:0] core_message,
  output logic [WIDTH-1:0] core_exponent,
  output logic [WIDTH-1:0] core_modulus,
  input  logic [WIDTH-1:0] core_cypher,
  input  logic             core_done
);

  localparam int NW = WIDTH / WORD;
  localparam int CW = $clog2(3 * NW);
  localparam int OW = $clog2(NW);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [OW-1:0]          ocnt_q, ocnt_d;
  logic                   s_ready_q, s_ready_d;
  logic                   acc, last_in, range_bad;
  logic [1:0]             sec;
  logic                   cy_load, cy_shift;
  logic [WIDTH-1:0]       cy_pin, cy_q;
  logic [2:0][WIDTH-1:0]  op_q;

  assign acc     = s_valid && s_ready_q;
  assign last_in = (cnt_q == CW'(3 * NW - 1));

  always_comb begin
    if (cnt_q < CW'(NW))          sec = SEC_MSG;
    else if (cnt_q < CW'(2 * NW)) sec = SEC_EXP;
    else                          sec = SEC_MOD;
  end

  // Operand registers only move on accepted beats of their own section, so they
  // stay frozen from the end of LOAD until the next job's first beat.
  for (genvar g = 0; g < 3; g++) begin : g_op
    rsa4k_wshift #(.WIDTH(WIDTH), .WORD(WORD)) u_op (
      .clk   (clk),
      .reset (reset),
      .shift (acc && (sec == 2'(g))),
      .load  (1'b0),
      .din   (s_data),
      .pin   ('0),
      .q     (op_q[g])
    );
  end

  rsa4k_wshift #(.WIDTH(WIDTH), .WORD(WORD)) u_cy (
    .clk   (clk),
    .reset (reset),
    .shift (cy_shift),
    .load  (cy_load),
    .din   ('0),
    .pin   (cy_pin),
    .q     (cy_q)
  );

  assign core_message  = op_q[SEC_MSG];
  assign core_exponent = op_q[SEC_EXP];
  assign core_modulus  = op_q[SEC_MOD];

`ifdef RSA4K_SIF_RANGE_CHECK_EN
  logic            lt_q, lt_d, lt_in, err_q, err_d;
  logic [OW-1:0]   widx;
  logic [WORD-1:0] m_w;

  // Message is fully loaded by the modulus section, so word i is compared
  // against modulus word i as it streams in.
  assign widx = OW'(cnt_q - CW'(2 * NW));
  assign m_w  = core_message[widx * WORD +: WORD];

  always_comb begin
    lt_d  = lt_q;
    err_d = err_q;
    lt_in = (cnt_q == CW'(2 * NW)) ? 1'b0 : lt_q;
    if (acc && (sec == SEC_MOD)) lt_d = (m_w < s_data) || ((m_w == s_data) && lt_in);
    if (acc && (cnt_q == '0))    err_d = 1'b0;
    if (acc && last_in && !lt_d) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lt_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      lt_q  <= lt_d;
      err_q <= err_d;
    end
  end

  assign range_bad = !lt_d;
  assign err       = err_q;
`else
  assign range_bad = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ocnt_d   = ocnt_q;
    cy_load  = 1'b0;
    cy_shift = 1'b0;
    cy_pin   = core_cypher;
    case (state_q)
      LOAD: begin
        if (acc) begin
          if (last_in) begin
            if (range_bad) begin
              state_d = DRAIN;
              cy_load = 1'b1;
              cy_pin  = '0;
            end else if (core_done) begin
              state_d = HOLD;
            end else begin
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      // Wait for the previous job's done to drop so go is not acknowledged early.
      HOLD: if (!core_done) state_d = RUN;
      RUN: begin
        if (core_done) begin
          state_d = DRAIN;
          cy_load = 1'b1;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          cy_shift = 1'b1;
          if (ocnt_q == OW'(NW - 1)) begin
            state_d = LOAD;
            ocnt_d  = '0;
            cnt_d   = '0;
          end else begin
            ocnt_d = ocnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    s_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      ocnt_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ocnt_q    <= ocnt_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = (state_q == DRAIN);
  assign m_data  = cy_q[WORD-1:0];
  assign m_last  = (state_q == DRAIN) && (ocnt_q == OW'(NW - 1));
  assign core_go = (state_q == RUN);
  assign busy    = (state_q == RUN) || (state_q == DRAIN);

endmodule

// File: doc/rsa4k_stream_if.md
# rsa4k_stream_if

Word-serial front/back end for the `rsa4k` modular-exponentiation core. It accepts message, exponent and modulus as a stream of WORD-bit beats and assembles them into the core's WIDTH-bit operand buses. It then drives the core's go/done handshake and streams the resulting cypher back out LSW-first. It sits directly between the system bus and `rsa4k`, and owns all of `rsa4k`'s operand ports.

## Interface
- WIDTH, 4096, operand width; must equal `rsa4k` width.
- WORD, 32, stream beat width; WIDTH % WORD == 0; NW = WIDTH/WORD (128 by default).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset; **one clock; reset is asynchronous and active-high**.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  WORD  operand word.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts beat.
- m_data  out  WORD  cypher word.
- m_last  out  1  high on the final (NW-th) output beat.
- busy  out  1  high in RUN and DRAIN.
- err  out  1  range-check failure for the current job (see Configuration).
- core_go  out  1  to `rsa4k.go`.
- core_message, core_exponent, core_modulus  out  WIDTH each  to `rsa4k`.
- core_cypher  in  WIDTH  from `rsa4k`.
- core_done  in  1  from `rsa4k`.

## Operation
- States: LOAD, HOLD, RUN, DRAIN.
- LOAD
  - s_ready = 1.
  - Accepts 3·NW beats in fixed order: message words 0..NW-1, then exponent, then modulus.
  - Each section is LSW first.
  - Beat counter: 0..3·NW-1; section = cnt / NW. Each beat shifts into the section's register from the MSB side (shift right by WORD).
  - After the last beat: go to RUN if core_done == 0, else HOLD.
- HOLD
  - Waits for core_done == 0, then goes to RUN.
  - s_ready = 0.
- RUN
  - core_go = 1, held until core_done is sampled 1.
  - On that edge: latch core_cypher, clear core_go, enter DRAIN.
- DRAIN
  - m_valid = 1; m_data = cypher register [WORD-1:0].
  - Each accepted beat shifts the cypher register right by WORD and increments the output counter.
  - m_last = 1 when the output counter == NW-1.
  - When the last beat is accepted, return to LOAD and clear counters.
- Operand registers hold their values from the end of LOAD until the next job's first beat, so `rsa4k` sees stable operands for the whole of RUN.
- Beats presented while s_ready == 0 are neither consumed nor stored.

## Timing
- Reset values (asynchronous):
  - State LOAD; all counters 0; all registers 0.
  - s_ready = 0, m_valid = 0, m_last = 0, core_go = 0, busy = 0, err = 0.
- s_ready is registered; it rises on the first clk edge after reset release.
- core_go rises on the edge that accepts the final modulus beat (or on HOLD exit), so it is visible the following cycle.
- If core_done is sampled 1 at edge E, then at E: core_go → 0, m_valid → 1, and the cypher is latched.
- If m_ready = 1 continuously, DRAIN lasts NW cycles. LOAD is re-entered, with s_ready = 1, the cycle after the last beat is accepted.
- Minimum overhead per job: 3·NW + NW + 2 cycles plus the core latency.
- While m_valid && !m_ready, m_data and m_last are held stable.
- Reset asserted mid-job: immediate return to reset values. The partial load or the cypher is discarded, and core_go drops without waiting for core_done.

## Configuration
- `RSA4K_SIF_RANGE_CHECK_EN` defined:
  - During the modulus section, compute a serial LSW-first compare: lt ← (m_i < n_i) || (m_i == n_i && lt).
  - lt starts at 0 at the beginning of the modulus section.
  - After the last beat, if !lt (message ≥ modulus): set err = 1, skip RUN (core_go never rises), load zero into the cypher register, and go straight to DRAIN.
  - err clears on the first beat of the next job.
- Not defined: no comparator is built, err is tied to 0, and every job goes through RUN.

## Structure
- Package `rsa4k_pkg`: state enum (LOAD, HOLD, RUN, DRAIN), section constants (SEC_MSG = 0, SEC_EXP = 1, SEC_MOD = 2), and default WIDTH/WORD localparams.
- One sub-module, `rsa4k_wshift`: a WIDTH-bit register with load-word-from-MSB / shift-right-by-WORD / parallel-load.
  - Instantiated four times: message, exponent, modulus, cypher.

## Test plan
- Encrypt: word 0 = 8 / 13 / 77, all other words 0, real `rsa4k` core → core_go rises one cycle after beat 384; output word 0 = 0x00000032, words 1..127 = 0, m_last on beat 128 only.
- Decrypt: word 0 = 0x32 / 37 / 77 → output word 0 = 0x00000008, err = 0.
- Backpressure: m_ready high one cycle in three → identical 128-word output; m_data and m_last unchanged in every stalled cycle.
- Input gaps and HOLD:
  - Random s_valid gaps during LOAD → same cypher.
  - s_valid held during RUN/DRAIN → s_ready = 0, no extra beats consumed.
  - Stub core holding core_done = 1 at end of LOAD → HOLD until done falls.
- Reset asserted 20 cycles into RUN → core_go, busy and s_ready are 0 the same cycle; a following full job then completes correctly.
- With `RSA4K_SIF_RANGE_CHECK_EN`, message = 77, modulus = 77 → err = 1, core_go stays 0, 128 zero words, m_last on beat 128. A following job of 8/13/77 → err = 0, output 0x32.
